// File: rtl/gyro_spi_seq_pkg.sv
// gyro_seq_pkg: state encoding, init write table, register addresses and
// the read-command builder shared by gyro_spi_seq.
// Optional feature macro: GYRO_SEQ_PITCH_ROLL_EN (adds pitch/roll reads).
package gyro_seq_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_SND,
    INIT_WT,
    IDLE,
    RD_SND,
    RD_WT
  } seq_state_t;

  localparam logic [15:0] INIT_TBL [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

  localparam logic [6:0] ADDR_YAW_L = 7'h26;
  localparam logic [6:0] ADDR_YAW_H = 7'h27;

`ifdef GYRO_SEQ_PITCH_ROLL_EN
  localparam logic [6:0] ADDR_PITCH_L = 7'h22;
  localparam logic [6:0] ADDR_PITCH_H = 7'h23;
  localparam logic [6:0] ADDR_ROLL_L  = 7'h24;
  localparam logic [6:0] ADDR_ROLL_H  = 7'h25;
  localparam int N_RD = 6;
  localparam logic [6:0] RD_LIST [6] = '{ADDR_PITCH_L, ADDR_PITCH_H, ADDR_ROLL_L,
                                         ADDR_ROLL_H, ADDR_YAW_L, ADDR_YAW_H};
`else
  localparam int N_RD = 2;
  localparam logic [6:0] RD_LIST [2] = '{ADDR_YAW_L, ADDR_YAW_H};
`endif

  localparam int RD_IW = $clog2(N_RD);

  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/gyro_spi_seq_if.sv
// gyro_spi_seq_if: SPI monarch handshake, sensor interrupt and rate outputs.
// Pitch/roll signals exist only when GYRO_SEQ_PITCH_ROLL_EN is defined.
interface gyro_spi_seq_if;
  logic        INT;
  logic        done;
  logic [15:0] resp;
  logic        snd;
  logic [15:0] cmd;
  logic        init_done;
  logic [15:0] yaw_raw;
  logic        yaw_rdy;
`ifdef GYRO_SEQ_PITCH_ROLL_EN
  logic [15:0] pitch_raw;
  logic [15:0] roll_raw;
  logic        pr_rdy;

  modport master (input INT, done, resp,
                  output snd, cmd, init_done, yaw_raw, yaw_rdy, pitch_raw, roll_raw, pr_rdy);
  modport slave  (output INT, done, resp,
                  input snd, cmd, init_done, yaw_raw, yaw_rdy, pitch_raw, roll_raw, pr_rdy);
`else
  modport master (input INT, done, resp,
                  output snd, cmd, init_done, yaw_raw, yaw_rdy);
  modport slave  (output INT, done, resp,
                  input snd, cmd, init_done, yaw_raw, yaw_rdy);
`endif
endinterface

// File: rtl/gyro_spi_seq_int_sync.sv
// int_sync: two-flop synchronizer for the async data-ready line followed by
// a registered rising-edge detect (one-cycle pulse).
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_rise
);

  logic r_s1, r_s2, r_s3, r_rise;

  // Synchronize, keep previous sample, register the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/gyro_spi_seq.sv
// gyro_spi_seq: power-up wait, fixed config writes, then a register-read
// burst per data-ready interrupt, assembling 16-bit rate words.
// Optional feature macro: GYRO_SEQ_PITCH_ROLL_EN (pitch/roll reads and outputs).
module gyro_spi_seq
  import gyro_seq_pkg::*;
#(
  parameter int unsigned INIT_WAIT = 65535
) (
  input logic            clk,
  input logic            rst,
  gyro_spi_seq_if.master bus
);

  seq_state_t       r_state, w_state_nxt;
  logic [15:0]      r_timer;
  logic [1:0]       r_init_idx;
  logic [RD_IW-1:0] r_rd_idx;
  logic             r_done_q, r_pend, r_init_done, r_yaw_rdy;
  logic [7:0]       r_yaw_lo;
  logic [15:0]      r_yaw_raw;
  logic             w_int_rise, w_done_rise, w_snd, w_init_last, w_rd_last;
  logic [15:0]      w_cmd;
  logic             w_resp_unused;

  int_sync u_int_sync (.clk(clk), .rst(rst), .i_in(bus.INT), .o_rise(w_int_rise));

  // done stays high across transactions, so only its rising edge marks completion
  assign w_done_rise   = bus.done & ~r_done_q;
  assign w_init_last   = (r_init_idx == 2'd3);
  assign w_rd_last     = (r_rd_idx == RD_IW'(N_RD - 1));
  assign w_resp_unused = ^bus.resp[15:8];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= PWR_WAIT;
    else     r_state <= w_state_nxt;
  end

  // Next state, snd pulse and command word (held from snd until the done edge)
  always_comb begin
    w_state_nxt = r_state;
    w_snd       = 1'b0;
    w_cmd       = 16'h0000;
    unique case (r_state)
      PWR_WAIT: if (r_timer == 16'd0) w_state_nxt = INIT_SND;
      INIT_SND: begin
        w_snd       = 1'b1;
        w_cmd       = INIT_TBL[r_init_idx];
        w_state_nxt = INIT_WT;
      end
      INIT_WT: begin
        w_cmd = INIT_TBL[r_init_idx];
        if (w_done_rise) w_state_nxt = w_init_last ? IDLE : INIT_SND;
      end
      IDLE: if (w_int_rise || r_pend) w_state_nxt = RD_SND;
      RD_SND: begin
        w_snd       = 1'b1;
        w_cmd       = rd_cmd(RD_LIST[r_rd_idx]);
        w_state_nxt = RD_WT;
      end
      RD_WT: begin
        w_cmd = rd_cmd(RD_LIST[r_rd_idx]);
        if (w_done_rise) w_state_nxt = w_rd_last ? IDLE : RD_SND;
      end
      default: w_state_nxt = PWR_WAIT;
    endcase
  end

  // Power-up timer, table indices, init_done and the single-depth pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer     <= 16'(INIT_WAIT);
      r_init_idx  <= 2'd0;
      r_rd_idx    <= '0;
      r_done_q    <= 1'b0;
      r_pend      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_done_q <= bus.done;
      if (r_state == PWR_WAIT && r_timer != 16'd0) r_timer <= r_timer - 16'd1;
      if (r_state == INIT_WT && w_done_rise) begin
        r_init_idx <= r_init_idx + 2'd1;
        if (w_init_last) r_init_done <= 1'b1;
      end
      if (r_state == RD_WT && w_done_rise) r_rd_idx <= w_rd_last ? '0 : r_rd_idx + 1'b1;
      // interrupts before init completes are dropped, not queued
      if (r_state == IDLE)                  r_pend <= 1'b0;
      else if (w_int_rise && r_init_done)   r_pend <= 1'b1;
    end
  end

`ifdef GYRO_SEQ_PITCH_ROLL_EN
  logic [7:0]  r_pr_b [4];
  logic [15:0] r_pitch_raw, r_roll_raw;
  logic        r_pr_rdy;
`endif

  // Capture response bytes and publish rate words after the final read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_yaw_lo  <= 8'h00;
      r_yaw_raw <= 16'h0000;
      r_yaw_rdy <= 1'b0;
`ifdef GYRO_SEQ_PITCH_ROLL_EN
      r_pr_b      <= '{default: 8'h00};
      r_pitch_raw <= 16'h0000;
      r_roll_raw  <= 16'h0000;
      r_pr_rdy    <= 1'b0;
`endif
    end else begin
      r_yaw_rdy <= 1'b0;
`ifdef GYRO_SEQ_PITCH_ROLL_EN
      r_pr_rdy <= 1'b0;
`endif
      if (r_state == RD_WT && w_done_rise) begin
        if (r_rd_idx == RD_IW'(N_RD - 2)) r_yaw_lo <= bus.resp[7:0];
`ifdef GYRO_SEQ_PITCH_ROLL_EN
        if (r_rd_idx < 3'd4) r_pr_b[r_rd_idx[1:0]] <= bus.resp[7:0];
`endif
        if (w_rd_last) begin
          r_yaw_raw <= {bus.resp[7:0], r_yaw_lo};
          r_yaw_rdy <= 1'b1;
`ifdef GYRO_SEQ_PITCH_ROLL_EN
          r_pitch_raw <= {r_pr_b[1], r_pr_b[0]};
          r_roll_raw  <= {r_pr_b[3], r_pr_b[2]};
          r_pr_rdy    <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.snd       = w_snd;
  assign bus.cmd       = w_cmd;
  assign bus.init_done = r_init_done;
  assign bus.yaw_raw   = r_yaw_raw;
  assign bus.yaw_rdy   = r_yaw_rdy;
`ifdef GYRO_SEQ_PITCH_ROLL_EN
  assign bus.pitch_raw = r_pitch_raw;
  assign bus.roll_raw  = r_roll_raw;
  assign bus.pr_rdy    = r_pr_rdy;
`endif

endmodule

// File: tb/tb_gyro_spi_seq.sv
// tb_gyro_spi_seq: directed bench for gyro_spi_seq with a behavioural SPI
// monarch that raises done a fixed latency after each snd.
module tb_gyro_spi_seq;

  localparam int INIT_WAIT = 16;
  localparam int DONE_LAT  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gyro_spi_seq_if bus();

  gyro_spi_seq #(.INIT_WAIT(INIT_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] cmd_log [$];
  int          snd_log [$];
  int          done_log [$];
  logic [7:0]  rsp_q [$];
  int yaw_rdy_cnt = 0, yaw_rdy_cyc = 0, overlap_cnt = 0, pr_rdy_cnt = 0, pr_skew_cnt = 0;
  bit busy = 1'b0, cur_rd = 1'b0;
  int lat_cnt = 0;

  logic [15:0] exp_init [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
`ifdef GYRO_SEQ_PITCH_ROLL_EN
  localparam int N_RD = 6;
  logic [15:0] exp_rd [6] = '{16'hA200, 16'hA300, 16'hA400, 16'hA500, 16'hA600, 16'hA700};
`else
  localparam int N_RD = 2;
  logic [15:0] exp_rd [2] = '{16'hA600, 16'hA700};
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // SPI monarch model plus output monitors
  initial begin
    bus.done = 1'b0;
    bus.resp = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.done = 1'b0;
        busy     = 1'b0;
      end else begin
        if (bus.yaw_rdy) begin
          yaw_rdy_cnt++;
          yaw_rdy_cyc = cyc;
          if (bus.snd) overlap_cnt++;
        end
`ifdef GYRO_SEQ_PITCH_ROLL_EN
        if (bus.pr_rdy) pr_rdy_cnt++;
        if (bus.pr_rdy !== bus.yaw_rdy) pr_skew_cnt++;
`endif
        if (bus.snd) begin
          bus.done = 1'b0;
          busy     = 1'b1;
          lat_cnt  = DONE_LAT;
          cur_rd   = bus.cmd[15];
          cmd_log.push_back(bus.cmd);
          snd_log.push_back(cyc);
        end else if (busy) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            busy = 1'b0;
            if (cur_rd && rsp_q.size() > 0) bus.resp = {8'h00, rsp_q.pop_front()};
            else                            bus.resp = 16'h0000;
            bus.done = 1'b1;
            done_log.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_log.delete(); snd_log.delete(); done_log.delete(); rsp_q.delete();
    yaw_rdy_cnt = 0; overlap_cnt = 0; pr_rdy_cnt = 0; pr_skew_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_logs();
  endtask

  task automatic release_rst(output int rel);
    @(negedge clk); rst = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_init(input int budget, output bit ok, output int seen);
    int k = 0;
    while (bus.init_done !== 1'b1 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    ok   = (bus.init_done === 1'b1);
    seen = cyc;
  endtask

  task automatic wait_yaw(input int n, input int budget, output bit ok);
    int k = 0;
    while (yaw_rdy_cnt < n && k < budget) begin
      @(posedge clk); #1; k++;
    end
    ok = (yaw_rdy_cnt >= n);
  endtask

  task automatic pulse_int();
    @(negedge clk); bus.INT = 1'b1;
    repeat (3) @(negedge clk);
    bus.INT = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_pair(input logic [7:0] lo, input logic [7:0] hi);
    for (int i = 0; i < N_RD - 2; i++) rsp_q.push_back(8'h00);
    rsp_q.push_back(lo);
    rsp_q.push_back(hi);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.snd !== 1'b0) begin n_err++; $display("FAIL reset_snd: got %b want 0", bus.snd); end
    n_vec++; if (bus.cmd !== 16'h0000) begin n_err++; $display("FAIL reset_cmd: got %h want 0000", bus.cmd); end
    n_vec++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b want 0", bus.init_done); end
    n_vec++; if (bus.yaw_raw !== 16'h0000) begin n_err++; $display("FAIL reset_yaw_raw: got %h want 0000", bus.yaw_raw); end
    n_vec++; if (bus.yaw_rdy !== 1'b0) begin n_err++; $display("FAIL reset_yaw_rdy: got %b want 0", bus.yaw_rdy); end
    n_vec++; if (dut.r_pend !== 1'b0) begin n_err++; $display("FAIL reset_pend: got %b want 0", dut.r_pend); end
  endtask

  task automatic check_init_seq(input string tag, input int rel, input bit ok, input int init_cyc);
    n_vec++; if (!ok) begin n_err++; $display("FAIL %s_timeout: init_done never rose", tag); end
    n_vec++; if (snd_log.size() != 4) begin n_err++; $display("FAIL %s_nwrites: got %0d want 4", tag, snd_log.size()); end
    n_vec++; if (snd_log[0] - rel != INIT_WAIT + 1) begin
      n_err++; $display("FAIL %s_first_snd: got cycle %0d want %0d", tag, snd_log[0] - rel, INIT_WAIT + 1);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (cmd_log[i] !== exp_init[i]) begin
        n_err++; $display("FAIL %s_cmd%0d: got %h want %h", tag, i, cmd_log[i], exp_init[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      n_vec++; if (snd_log[i] != done_log[i-1] + 1) begin
        n_err++; $display("FAIL %s_b2b%0d: snd at %0d want %0d", tag, i, snd_log[i], done_log[i-1] + 1);
      end
    end
    n_vec++; if (init_cyc != done_log[3] + 1) begin
      n_err++; $display("FAIL %s_init_done_cyc: got %0d want %0d", tag, init_cyc, done_log[3] + 1);
    end
  endtask

  task automatic test_power_up();
    int rel, init_cyc;
    bit ok;
    clear_logs();
    release_rst(rel);
    wait_init(600, ok, init_cyc);
    check_init_seq("pwrup", rel, ok, init_cyc);
    wait_cyc(2);
  endtask

  task automatic test_yaw_read();
    int k = 0;
    bit ok;
    clear_logs();
    push_pair(8'h34, 8'h12);
    @(negedge clk); bus.INT = 1'b1;
    while (bus.snd !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    bus.INT = 1'b0;
    n_vec++; if (k != 4) begin n_err++; $display("FAIL int_to_snd: got %0d cycles want 4", k); end
    wait_yaw(1, 600, ok);
    wait_cyc(5);
    n_vec++; if (!ok) begin n_err++; $display("FAIL yaw_timeout: yaw_rdy never seen"); end
    n_vec++; if (cmd_log.size() != N_RD) begin n_err++; $display("FAIL yaw_nreads: got %0d want %0d", cmd_log.size(), N_RD); end
    for (int i = 0; i < N_RD; i++) begin
      n_vec++; if (cmd_log[i] !== exp_rd[i]) begin
        n_err++; $display("FAIL yaw_cmd%0d: got %h want %h", i, cmd_log[i], exp_rd[i]);
      end
    end
    n_vec++; if (bus.yaw_raw !== 16'h1234) begin n_err++; $display("FAIL yaw_raw: got %h want 1234", bus.yaw_raw); end
    n_vec++; if (yaw_rdy_cnt != 1) begin n_err++; $display("FAIL yaw_rdy_width: got %0d cycles want 1", yaw_rdy_cnt); end
    n_vec++; if (overlap_cnt != 0) begin n_err++; $display("FAIL yaw_rdy_snd_overlap: got %0d want 0", overlap_cnt); end
    n_vec++; if (yaw_rdy_cyc != done_log[N_RD-1] + 1) begin
      n_err++; $display("FAIL yaw_rdy_cyc: got %0d want %0d", yaw_rdy_cyc, done_log[N_RD-1] + 1);
    end
    n_vec++; if (snd_log[1] != done_log[0] + 1) begin
      n_err++; $display("FAIL rd_b2b: snd at %0d want %0d", snd_log[1], done_log[0] + 1);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    bit ok;
    clear_logs();
    push_pair(8'h78, 8'h56);
    push_pair(8'hBC, 8'h9A);
    pulse_int();
    while (snd_log.size() < 1 && k < 20) begin @(posedge clk); #1; k++; end
    wait_cyc(2);
    pulse_int();
    wait_yaw(2, 1500, ok);
    wait_cyc(5);
    n_vec++; if (!ok) begin n_err++; $display("FAIL pend_timeout: second yaw_rdy never seen"); end
    n_vec++; if (cmd_log.size() != 2 * N_RD) begin n_err++; $display("FAIL pend_nreads: got %0d want %0d", cmd_log.size(), 2 * N_RD); end
    n_vec++; if (snd_log[N_RD] != done_log[N_RD-1] + 2) begin
      n_err++; $display("FAIL pend_restart: snd at %0d want %0d", snd_log[N_RD], done_log[N_RD-1] + 2);
    end
    n_vec++; if (bus.yaw_raw !== 16'h9ABC) begin n_err++; $display("FAIL pend_yaw_raw: got %h want 9abc", bus.yaw_raw); end
    n_vec++; if (yaw_rdy_cnt != 2) begin n_err++; $display("FAIL pend_yaw_rdy_cnt: got %0d want 2", yaw_rdy_cnt); end
    n_vec++; if (overlap_cnt != 0) begin n_err++; $display("FAIL pend_overlap: got %0d want 0", overlap_cnt); end
    n_vec++; if (dut.r_pend !== 1'b0) begin n_err++; $display("FAIL pend_clear: got %b want 0", dut.r_pend); end
  endtask

  task automatic test_multi_int();
    int k = 0;
    bit ok;
    clear_logs();
    push_pair(8'h33, 8'h44);
    push_pair(8'h11, 8'h22);
    pulse_int();
    while (snd_log.size() < 1 && k < 20) begin @(posedge clk); #1; k++; end
    repeat (3) pulse_int();
    wait_yaw(2, 1500, ok);
    wait_cyc(N_RD * (DONE_LAT + 5) + 20);
    n_vec++; if (!ok) begin n_err++; $display("FAIL multi_timeout: second yaw_rdy never seen"); end
    n_vec++; if (cmd_log.size() != 2 * N_RD) begin n_err++; $display("FAIL multi_nreads: got %0d want %0d", cmd_log.size(), 2 * N_RD); end
    n_vec++; if (yaw_rdy_cnt != 2) begin n_err++; $display("FAIL multi_yaw_rdy_cnt: got %0d want 2", yaw_rdy_cnt); end
    n_vec++; if (bus.yaw_raw !== 16'h2211) begin n_err++; $display("FAIL multi_yaw_raw: got %h want 2211", bus.yaw_raw); end
  endtask

  task automatic test_int_in_pwr_wait();
    int rel, init_cyc;
    bit ok;
    do_reset();
    release_rst(rel);
    wait_cyc(2);
    pulse_int();
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (dut.r_pend !== 1'b0) begin n_err++; $display("FAIL pwr_wait_pend%0d: got %b want 0", i, dut.r_pend); end
      wait_cyc(1);
    end
    wait_init(600, ok, init_cyc);
    wait_cyc(150);
    n_vec++; if (!ok) begin n_err++; $display("FAIL pwr_wait_timeout: init_done never rose"); end
    n_vec++; if (cmd_log.size() != 4) begin n_err++; $display("FAIL pwr_wait_ncmds: got %0d want 4", cmd_log.size()); end
    n_vec++; if (yaw_rdy_cnt != 0) begin n_err++; $display("FAIL pwr_wait_yaw_rdy: got %0d want 0", yaw_rdy_cnt); end
    n_vec++; if (dut.r_pend !== 1'b0) begin n_err++; $display("FAIL pwr_wait_pend_end: got %b want 0", dut.r_pend); end
  endtask

  task automatic test_reset_mid_init();
    int rel, init_cyc, k = 0;
    bit ok;
    do_reset();
    release_rst(rel);
    while (snd_log.size() < 2 && k < 200) begin @(posedge clk); #1; k++; end
    wait_cyc(10);
    n_vec++; if (bus.cmd !== 16'h1053) begin n_err++; $display("FAIL mid_cmd_hold: got %h want 1053", bus.cmd); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.snd !== 1'b0) begin n_err++; $display("FAIL mid_rst_snd: got %b want 0", bus.snd); end
    n_vec++; if (bus.cmd !== 16'h0000) begin n_err++; $display("FAIL mid_rst_cmd: got %h want 0000", bus.cmd); end
    n_vec++; if (bus.init_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_init_done: got %b want 0", bus.init_done); end
    n_vec++; if (bus.yaw_rdy !== 1'b0) begin n_err++; $display("FAIL mid_rst_yaw_rdy: got %b want 0", bus.yaw_rdy); end
    n_vec++; if (dut.r_pend !== 1'b0) begin n_err++; $display("FAIL mid_rst_pend: got %b want 0", dut.r_pend); end
    wait_cyc(1);
    clear_logs();
    release_rst(rel);
    wait_init(600, ok, init_cyc);
    check_init_seq("restart", rel, ok, init_cyc);
    wait_cyc(2);
  endtask

`ifdef GYRO_SEQ_PITCH_ROLL_EN
  task automatic test_pitch_roll();
    bit ok;
    clear_logs();
    for (int i = 1; i <= 6; i++) rsp_q.push_back(8'(i));
    pulse_int();
    wait_yaw(1, 800, ok);
    wait_cyc(5);
    n_vec++; if (!ok) begin n_err++; $display("FAIL pr_timeout: yaw_rdy never seen"); end
    n_vec++; if (bus.pitch_raw !== 16'h0201) begin n_err++; $display("FAIL pr_pitch: got %h want 0201", bus.pitch_raw); end
    n_vec++; if (bus.roll_raw !== 16'h0403) begin n_err++; $display("FAIL pr_roll: got %h want 0403", bus.roll_raw); end
    n_vec++; if (bus.yaw_raw !== 16'h0605) begin n_err++; $display("FAIL pr_yaw: got %h want 0605", bus.yaw_raw); end
    n_vec++; if (pr_rdy_cnt != 1) begin n_err++; $display("FAIL pr_rdy_cnt: got %0d want 1", pr_rdy_cnt); end
    n_vec++; if (pr_skew_cnt != 0) begin n_err++; $display("FAIL pr_rdy_align: got %0d skewed cycles want 0", pr_skew_cnt); end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (cmd_log[i] !== exp_rd[i]) begin
        n_err++; $display("FAIL pr_cmd%0d: got %h want %h", i, cmd_log[i], exp_rd[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.INT = 1'b0;
    test_reset();
    test_power_up();
    test_yaw_read();
    test_back_to_back();
    test_multi_int();
    test_int_in_pwr_wait();
    test_reset_mid_init();
`ifdef GYRO_SEQ_PITCH_ROLL_EN
    test_pitch_roll();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
